lru_replacer: RTL

Parametrised true-LRU replacement unit for a WAYS-way, SETS-set cache. It holds per-set way ages and valid bits, and returns a one-cycle-latency replacement decision per lookup. On a miss it fills invalid ways first, lowest index first, and otherwise picks the least-recently-used way. It sits beside the tag array in the cache controller. It also supports per-way invalidation and a multi-cycle whole-cache flush.

---
 rtl/lru_replacer_if.sv | 39 +++
 rtl/lru_replacer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/lru_replacer_if.sv
// ============================================================================
// lru_replacer_if : lookup/invalidate/flush bus between controller and LRU unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface lru_replacer_if #(
  parameter int WAYS = 4,
  parameter int SETS = 16
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  logic             req_valid;
  logic [IDX_W-1:0] req_index;
  logic             req_hit;
  logic [WAY_W-1:0] req_way;
  logic             inv_valid;
  logic [IDX_W-1:0] inv_index;
  logic [WAY_W-1:0] inv_way;
  logic             flush;
  logic             resp_valid;
  logic [WAY_W-1:0] resp_way;
  logic             busy;

  modport master (
    output req_valid, req_index, req_hit, req_way,
    output inv_valid, inv_index, inv_way, flush,
    input  resp_valid, resp_way, busy
  );

  modport slave (
    input  req_valid, req_index, req_hit, req_way,
    input  inv_valid, inv_index, inv_way, flush,
    output resp_valid, resp_way, busy
  );
endinterface

`default_nettype wire

// File: rtl/lru_replacer.sv
// ============================================================================
// lru_replacer : true-LRU victim selection with per-way valid bits and flush
// Rev 1.0
// ============================================================================
`default_nettype none

module lru_replacer #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic               clk,
  input  logic               reset,
  lru_replacer_if.slave      bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int IDX_W = $clog2(SETS);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] fc;

  logic [WAYS-1:0]  valid_mem [SETS];
  logic [WAY_W-1:0] age_mem   [SETS][WAYS];

  logic             accept;
  logic [WAYS-1:0]  set_valid;
  logic [WAY_W-1:0] set_age   [WAYS];
  logic [WAY_W-1:0] new_age   [WAYS];
  logic             free_found;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] target;
  logic             resp_valid_q;
  logic [WAY_W-1:0] resp_way_q;

  assign accept = bus.req_valid && (state == IDLE);

  // Victim choice: lowest invalid way first, otherwise the oldest way.
  always_comb begin
    set_valid  = valid_mem[bus.req_index];
    free_found = 1'b0;
    free_way   = '0;
    lru_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_age[w] = age_mem[bus.req_index][w];
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end
    for (int w = 0; w < WAYS; w++) begin
      if (set_age[w] == WAY_W'(WAYS - 1)) begin
        lru_way = WAY_W'(w);
      end
    end
    if (bus.req_hit) begin
      target = bus.req_way;
    end else if (free_found) begin
      target = free_way;
    end else begin
      target = lru_way;
    end
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == target) begin
        new_age[w] = '0;
      end else if (set_age[w] < set_age[target]) begin
        new_age[w] = set_age[w] + WAY_W'(1);
      end else begin
        new_age[w] = set_age[w];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.flush) state_next = FLUSH;
      FLUSH:   if (fc == IDX_W'(SETS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      fc    <= '0;
    end else begin
      state <= state_next;
      fc    <= (state == FLUSH) ? fc + IDX_W'(1) : '0;
    end
  end

  // Invalidate is written last so it overrides a fill of the same way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_mem[s][w] <= WAY_W'(w);
        end
      end
    end else if (state == FLUSH) begin
      valid_mem[fc] <= '0;
      for (int w = 0; w < WAYS; w++) begin
        age_mem[fc][w] <= WAY_W'(w);
      end
    end else begin
      if (accept) begin
        for (int w = 0; w < WAYS; w++) begin
          age_mem[bus.req_index][w] <= new_age[w];
        end
        if (!bus.req_hit) begin
          valid_mem[bus.req_index][target] <= 1'b1;
        end
      end
      if (bus.inv_valid) begin
        valid_mem[bus.inv_index][bus.inv_way] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
    end else begin
      resp_valid_q <= accept;
      if (accept) begin
        resp_way_q <= target;
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_way   = resp_way_q;
  assign bus.busy       = (state == FLUSH);

endmodule

`default_nettype wire
